hazard_mdu_ctrl: RTL and testbench

HAZARD_MDU_CTRL -- requirements
Module: hazard_mdu_ctrl

---
 rtl/hazard_mdu_ctrl_pkg.sv | 27 ++
 rtl/hazard_mdu_ctrl_md_busy_ctr.sv | 44 ++++
 rtl/hazard_mdu_ctrl.sv | 94 +++++++++
 tb/tb_hazard_mdu_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_mdu_ctrl_pkg.sv
// Shared constants for the hazard / MDU control slice: forward-select codes,
// default MDU latencies and the forward priority helper.
package hazard_mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FROM_E   = 2'd1,
        FROM_M   = 2'd2,
        FROM_W   = 2'd3
    } fwd_sel_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Nearest ready producer wins; callers pass 0 for stages they never forward from.
    function automatic fwd_sel_e fwd_prio(input logic e_ok, input logic m_ok, input logic w_ok);
        if (e_ok) begin
            return FROM_E;
        end else if (m_ok) begin
            return FROM_M;
        end else if (w_ok) begin
            return FROM_W;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_mdu_ctrl_md_busy_ctr.sv
// MDU busy counter: loads the operation latency on a start, counts down to 0
// and reports busy while non-zero.
module md_busy_ctr
    import hazard_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int CNT_W = $clog2(DIV_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? DIV_LD : MULT_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is asynchronous so an abort is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_mdu_ctrl.sv
// Pipeline hazard unit: data-stall detection, forward selects for D/E/M,
// and multiply/divide structural stall driven by the MDU busy counter.
module hazard_mdu_ctrl
    import hazard_mdu_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TW-1:0]     T_use_RS,
    input  logic [TW-1:0]     T_use_RT,
    input  logic [TW-1:0]     E_Tnew,
    input  logic [TW-1:0]     M_Tnew,
    input  logic [ADDR_W-1:0] D_A1,
    input  logic [ADDR_W-1:0] D_A2,
    input  logic [ADDR_W-1:0] E_A1,
    input  logic [ADDR_W-1:0] E_A2,
    input  logic [ADDR_W-1:0] E_A3,
    input  logic [ADDR_W-1:0] M_A2,
    input  logic [ADDR_W-1:0] M_A3,
    input  logic [ADDR_W-1:0] W_A3,
    input  logic              E_RFWr,
    input  logic              M_RFWr,
    input  logic              W_RFWr,
    input  logic              D_IsMD,
    input  logic              E_MDStart,
    input  logic              E_MDIsDiv,
    output logic              Stall,
    output logic              MD_Busy,
    output logic [1:0]        Fwd_D_RS_Sel,
    output logic [1:0]        Fwd_D_RT_Sel,
    output logic [1:0]        Fwd_E_A_Sel,
    output logic [1:0]        Fwd_E_B_Sel,
    output logic [1:0]        Fwd_M_WD_Sel
);

    // A consumer matches a producer only for a real (non-zero) register being written.
    function automatic logic hit(input logic [ADDR_W-1:0] src,
                                 input logic [ADDR_W-1:0] dst,
                                 input logic              wr);
        return (src != '0) && (src == dst) && wr;
    endfunction

    logic d1_e, d1_m, d1_w, d2_e, d2_m, d2_w;
    logic e1_m, e1_w, e2_m, e2_w, m2_w;
    logic e_ready, m_ready;
    logic stall_data, stall_md;

    assign d1_e = hit(D_A1, E_A3, E_RFWr);
    assign d1_m = hit(D_A1, M_A3, M_RFWr);
    assign d1_w = hit(D_A1, W_A3, W_RFWr);
    assign d2_e = hit(D_A2, E_A3, E_RFWr);
    assign d2_m = hit(D_A2, M_A3, M_RFWr);
    assign d2_w = hit(D_A2, W_A3, W_RFWr);
    assign e1_m = hit(E_A1, M_A3, M_RFWr);
    assign e1_w = hit(E_A1, W_A3, W_RFWr);
    assign e2_m = hit(E_A2, M_A3, M_RFWr);
    assign e2_w = hit(E_A2, W_A3, W_RFWr);
    assign m2_w = hit(M_A2, W_A3, W_RFWr);

    assign e_ready = (E_Tnew == '0);
    assign m_ready = (M_Tnew == '0);

    // Stall when the consumer needs the value before the producer can deliver it.
    assign stall_data = (d1_e && (T_use_RS < E_Tnew)) ||
                        (d1_m && (T_use_RS < M_Tnew)) ||
                        (d2_e && (T_use_RT < E_Tnew)) ||
                        (d2_m && (T_use_RT < M_Tnew));

    assign Fwd_D_RS_Sel = fwd_prio(d1_e && e_ready, d1_m && m_ready, d1_w);
    assign Fwd_D_RT_Sel = fwd_prio(d2_e && e_ready, d2_m && m_ready, d2_w);
    assign Fwd_E_A_Sel  = fwd_prio(1'b0, e1_m && m_ready, e1_w);
    assign Fwd_E_B_Sel  = fwd_prio(1'b0, e2_m && m_ready, e2_w);
    assign Fwd_M_WD_Sel = fwd_prio(1'b0, 1'b0, m2_w);

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (E_MDStart),
        .is_div_i (E_MDIsDiv),
        .busy_o   (MD_Busy)
    );

    // A start sitting in E counts as busy for the MD op in D in the same cycle.
    assign stall_md = D_IsMD && (MD_Busy || E_MDStart);
    assign Stall    = stall_data || stall_md;

endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// Directed bench for hazard_mdu_ctrl: default instance plus a widened
// instance (ADDR_W=6, TW=3, DIV_CYC=20) sharing clock and reset.
module tb_hazard_mdu_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic [1:0] T_use_RS, T_use_RT, E_Tnew, M_Tnew;
    logic [4:0] D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3;
    logic       E_RFWr, M_RFWr, W_RFWr, D_IsMD, E_MDStart, E_MDIsDiv;
    logic       Stall, MD_Busy;
    logic [1:0] Fwd_D_RS_Sel, Fwd_D_RT_Sel, Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel;

    // Wide instance
    logic [2:0] w_T_use_RS, w_T_use_RT, w_E_Tnew, w_M_Tnew;
    logic [5:0] w_D_A1, w_D_A2, w_E_A1, w_E_A2, w_E_A3, w_M_A2, w_M_A3, w_W_A3;
    logic       w_E_RFWr, w_M_RFWr, w_W_RFWr, w_D_IsMD, w_E_MDStart, w_E_MDIsDiv;
    logic       w_Stall, w_MD_Busy;
    logic [1:0] w_Fwd_D_RS_Sel, w_Fwd_D_RT_Sel, w_Fwd_E_A_Sel, w_Fwd_E_B_Sel, w_Fwd_M_WD_Sel;

    hazard_mdu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .T_use_RS(T_use_RS), .T_use_RT(T_use_RT), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .D_A1(D_A1), .D_A2(D_A2), .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3),
        .M_A2(M_A2), .M_A3(M_A3), .W_A3(W_A3),
        .E_RFWr(E_RFWr), .M_RFWr(M_RFWr), .W_RFWr(W_RFWr),
        .D_IsMD(D_IsMD), .E_MDStart(E_MDStart), .E_MDIsDiv(E_MDIsDiv),
        .Stall(Stall), .MD_Busy(MD_Busy),
        .Fwd_D_RS_Sel(Fwd_D_RS_Sel), .Fwd_D_RT_Sel(Fwd_D_RT_Sel),
        .Fwd_E_A_Sel(Fwd_E_A_Sel), .Fwd_E_B_Sel(Fwd_E_B_Sel), .Fwd_M_WD_Sel(Fwd_M_WD_Sel)
    );

    hazard_mdu_ctrl #(.ADDR_W(6), .TW(3), .DIV_CYC(20)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .T_use_RS(w_T_use_RS), .T_use_RT(w_T_use_RT), .E_Tnew(w_E_Tnew), .M_Tnew(w_M_Tnew),
        .D_A1(w_D_A1), .D_A2(w_D_A2), .E_A1(w_E_A1), .E_A2(w_E_A2), .E_A3(w_E_A3),
        .M_A2(w_M_A2), .M_A3(w_M_A3), .W_A3(w_W_A3),
        .E_RFWr(w_E_RFWr), .M_RFWr(w_M_RFWr), .W_RFWr(w_W_RFWr),
        .D_IsMD(w_D_IsMD), .E_MDStart(w_E_MDStart), .E_MDIsDiv(w_E_MDIsDiv),
        .Stall(w_Stall), .MD_Busy(w_MD_Busy),
        .Fwd_D_RS_Sel(w_Fwd_D_RS_Sel), .Fwd_D_RT_Sel(w_Fwd_D_RT_Sel),
        .Fwd_E_A_Sel(w_Fwd_E_A_Sel), .Fwd_E_B_Sel(w_Fwd_E_B_Sel), .Fwd_M_WD_Sel(w_Fwd_M_WD_Sel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        T_use_RS = '0; T_use_RT = '0; E_Tnew = '0; M_Tnew = '0;
        D_A1 = '0; D_A2 = '0; E_A1 = '0; E_A2 = '0; E_A3 = '0; M_A2 = '0; M_A3 = '0; W_A3 = '0;
        E_RFWr = 1'b0; M_RFWr = 1'b0; W_RFWr = 1'b0;
        D_IsMD = 1'b0; E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
    endtask

    task automatic idle_w;
        w_T_use_RS = '0; w_T_use_RT = '0; w_E_Tnew = '0; w_M_Tnew = '0;
        w_D_A1 = '0; w_D_A2 = '0; w_E_A1 = '0; w_E_A2 = '0; w_E_A3 = '0;
        w_M_A2 = '0; w_M_A3 = '0; w_W_A3 = '0;
        w_E_RFWr = 1'b0; w_M_RFWr = 1'b0; w_W_RFWr = 1'b0;
        w_D_IsMD = 1'b0; w_E_MDStart = 1'b0; w_E_MDIsDiv = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        idle_w();
        #3;
        checks++;
        if (MD_Busy !== 1'b0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_out busy=%b stall=%b expected 0/0", MD_Busy, Stall);
        end
        checks++;
        if ({Fwd_D_RS_Sel, Fwd_D_RT_Sel, Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel} !== 10'd0) begin
            errors++;
            $display("FAIL reset_fwd got %b expected all zero",
                     {Fwd_D_RS_Sel, Fwd_D_RT_Sel, Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel});
        end
        checks++;
        if (w_MD_Busy !== 1'b0 || w_Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide busy=%b stall=%b expected 0/0", w_MD_Busy, w_Stall);
        end
        #9 rst_n = 1'b1;
    endtask

    task automatic test_data_stall;
        tick();
        idle();
        E_A3 = 5'd8; E_RFWr = 1'b1; E_Tnew = 2'd1; D_A1 = 5'd8; T_use_RS = 2'd0;
        #1;
        checks++;
        if (Stall !== 1'b1 || Fwd_D_RS_Sel !== 2'd0) begin
            errors++;
            $display("FAIL e_not_ready stall=%b fwd=%0d expected 1/0", Stall, Fwd_D_RS_Sel);
        end
        E_Tnew = 2'd0;
        #1;
        checks++;
        if (Stall !== 1'b0 || Fwd_D_RS_Sel !== 2'd1) begin
            errors++;
            $display("FAIL e_ready stall=%b fwd=%0d expected 0/1", Stall, Fwd_D_RS_Sel);
        end
        E_Tnew = 2'd2; T_use_RS = 2'd2;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL tuse_eq_tnew stall=%b expected 0", Stall);
        end
        T_use_RS = 2'd1;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL tuse_lt_tnew stall=%b expected 1", Stall);
        end
        idle();
        D_A2 = 5'd7; M_A3 = 5'd7; M_RFWr = 1'b1; M_Tnew = 2'd2; T_use_RT = 2'd1;
        #1;
        checks++;
        if (Stall !== 1'b1 || Fwd_D_RT_Sel !== 2'd0) begin
            errors++;
            $display("FAIL rt_vs_m stall=%b fwd=%0d expected 1/0", Stall, Fwd_D_RT_Sel);
        end
        M_RFWr = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL rt_m_nowr stall=%b expected 0", Stall);
        end
        idle();
        E_A3 = 5'd0; E_RFWr = 1'b1; E_Tnew = 2'd3; D_A1 = 5'd0;
        #1;
        checks++;
        if (Stall !== 1'b0 || Fwd_D_RS_Sel !== 2'd0) begin
            errors++;
            $display("FAIL zero_addr stall=%b fwd=%0d expected 0/0", Stall, Fwd_D_RS_Sel);
        end
    endtask

    task automatic test_forward;
        tick();
        idle();
        M_A3 = 5'd9; W_A3 = 5'd9; M_RFWr = 1'b1; W_RFWr = 1'b1; M_Tnew = 2'd0;
        E_A2 = 5'd9; M_A2 = 5'd9; D_A1 = 5'd9;
        #1;
        checks++;
        if (Fwd_E_B_Sel !== 2'd2 || Fwd_M_WD_Sel !== 2'd3 || Fwd_D_RS_Sel !== 2'd2) begin
            errors++;
            $display("FAIL fwd_m_over_w eb=%0d mwd=%0d drs=%0d expected 2/3/2",
                     Fwd_E_B_Sel, Fwd_M_WD_Sel, Fwd_D_RS_Sel);
        end
        E_A3 = 5'd9; E_RFWr = 1'b1; E_Tnew = 2'd0;
        #1;
        checks++;
        if (Fwd_D_RS_Sel !== 2'd1 || Stall !== 1'b0 || Fwd_E_B_Sel !== 2'd2) begin
            errors++;
            $display("FAIL fwd_e_first drs=%0d stall=%b eb=%0d expected 1/0/2",
                     Fwd_D_RS_Sel, Stall, Fwd_E_B_Sel);
        end
        M_Tnew = 2'd1;
        #1;
        checks++;
        if (Fwd_E_B_Sel !== 2'd3 || Stall !== 1'b1 || Fwd_D_RS_Sel !== 2'd1) begin
            errors++;
            $display("FAIL fwd_m_late eb=%0d stall=%b drs=%0d expected 3/1/1",
                     Fwd_E_B_Sel, Stall, Fwd_D_RS_Sel);
        end
        D_A1 = 5'd0; E_A3 = 5'd0; M_Tnew = 2'd0;
        #1;
        checks++;
        if (Fwd_D_RS_Sel !== 2'd0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL fwd_zero drs=%0d stall=%b expected 0/0", Fwd_D_RS_Sel, Stall);
        end
        M_RFWr = 1'b0; E_A1 = 5'd9;
        #1;
        checks++;
        if (Fwd_E_A_Sel !== 2'd3 || Fwd_E_B_Sel !== 2'd3) begin
            errors++;
            $display("FAIL fwd_w_only ea=%0d eb=%0d expected 3/3", Fwd_E_A_Sel, Fwd_E_B_Sel);
        end
    endtask

    task automatic test_mult_stall;
        tick();
        idle();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b0; D_IsMD = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b1 || MD_Busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_start stall=%b busy=%b expected 1/0", Stall, MD_Busy);
        end
        tick();
        E_MDStart = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Stall !== 1'b1 || MD_Busy !== 1'b1) begin
                errors++;
                $display("FAIL mult_busy cyc%0d stall=%b busy=%b expected 1/1", i, Stall, MD_Busy);
            end
            tick();
        end
        checks++;
        if (Stall !== 1'b0 || MD_Busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_done stall=%b busy=%b expected 0/0", Stall, MD_Busy);
        end
    endtask

    task automatic test_back_to_back;
        tick();
        idle();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1;
        tick();
        E_MDStart = 1'b0;
        tick();
        tick();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b0;
        #1;
        checks++;
        if (MD_Busy !== 1'b1) begin
            errors++;
            $display("FAIL div_running busy=%b expected 1", MD_Busy);
        end
        tick();
        E_MDStart = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (MD_Busy !== 1'b1) begin
                errors++;
                $display("FAIL reload_busy cyc%0d busy=%b expected 1", i, MD_Busy);
            end
            tick();
        end
        checks++;
        if (MD_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_done busy=%b expected 0", MD_Busy);
        end
    endtask

    task automatic test_reset_abort;
        tick();
        idle();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1;
        tick();
        E_MDStart = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        D_IsMD = 1'b1;
        checks++;
        if (MD_Busy !== 1'b0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate busy=%b stall=%b expected 0/0", MD_Busy, Stall);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (MD_Busy !== 1'b0 || Stall !== 1'b0) begin
                errors++;
                $display("FAIL abort_after cyc%0d busy=%b stall=%b expected 0/0", i, MD_Busy, Stall);
            end
        end
        D_IsMD = 1'b0;
    endtask

    task automatic test_wide;
        logic x_seen;
        int   busy_cycles;
        x_seen = 1'b0;
        tick();
        idle_w();
        w_E_A3 = 6'd40; w_E_RFWr = 1'b1; w_E_Tnew = 3'd4; w_D_A1 = 6'd40; w_T_use_RS = 3'd3;
        #1;
        checks++;
        if (w_Stall !== 1'b1 || w_Fwd_D_RS_Sel !== 2'd0) begin
            errors++;
            $display("FAIL wide_e_not_ready stall=%b fwd=%0d expected 1/0", w_Stall, w_Fwd_D_RS_Sel);
        end
        w_E_Tnew = 3'd0;
        #1;
        checks++;
        if (w_Stall !== 1'b0 || w_Fwd_D_RS_Sel !== 2'd1) begin
            errors++;
            $display("FAIL wide_e_ready stall=%b fwd=%0d expected 0/1", w_Stall, w_Fwd_D_RS_Sel);
        end
        tick();
        idle_w();
        w_E_MDStart = 1'b1; w_D_IsMD = 1'b1;
        #1;
        checks++;
        if (w_Stall !== 1'b1) begin
            errors++;
            $display("FAIL wide_mult_start stall=%b expected 1", w_Stall);
        end
        tick();
        w_E_MDStart = 1'b0;
        #1;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (w_MD_Busy === 1'b1 && w_Stall === 1'b1) busy_cycles++;
            if ($isunknown({w_Stall, w_MD_Busy, w_Fwd_D_RS_Sel, w_Fwd_D_RT_Sel,
                            w_Fwd_E_A_Sel, w_Fwd_E_B_Sel, w_Fwd_M_WD_Sel})) x_seen = 1'b1;
            tick();
        end
        checks++;
        if (busy_cycles != 5) begin
            errors++;
            $display("FAIL wide_mult_len got %0d cycles expected 5", busy_cycles);
        end
        w_E_MDStart = 1'b1; w_E_MDIsDiv = 1'b1;
        tick();
        w_E_MDStart = 1'b0;
        #1;
        busy_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            if (w_MD_Busy === 1'b1) busy_cycles++;
            if ($isunknown({w_Stall, w_MD_Busy, w_Fwd_D_RS_Sel, w_Fwd_D_RT_Sel,
                            w_Fwd_E_A_Sel, w_Fwd_E_B_Sel, w_Fwd_M_WD_Sel})) x_seen = 1'b1;
            tick();
        end
        checks++;
        if (busy_cycles != 20) begin
            errors++;
            $display("FAIL wide_div_len got %0d cycles expected 20", busy_cycles);
        end
        checks++;
        if (x_seen !== 1'b0 || $isunknown({Stall, MD_Busy, Fwd_D_RS_Sel, Fwd_D_RT_Sel,
                                           Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel})) begin
            errors++;
            $display("FAIL no_x x_seen=%b expected 0", x_seen);
        end
    endtask

    initial begin
        test_reset();
        test_data_stall();
        test_forward();
        test_mult_stall();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
